// File: rtl/video_meter_pkg.sv
// Shared constants and types for the video timing meter: mode codes,
// reference line counts and the measurement FSM states.
package video_meter_pkg;

  localparam logic [1:0] MODE_NTSC15 = 2'd0;
  localparam logic [1:0] MODE_PAL15  = 2'd1;
  localparam logic [1:0] MODE_NTSC31 = 2'd2;
  localparam logic [1:0] MODE_PAL31  = 2'd3;

  localparam logic [31:0] LINES_NTSC15 = 32'd262;
  localparam logic [31:0] LINES_PAL15  = 32'd312;
  localparam logic [31:0] LINES_NTSC31 = 32'd524;
  localparam logic [31:0] LINES_PAL31  = 32'd624;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    LOCKED
  } state_t;

endpackage

// File: rtl/video_edge_det.sv
// Rise/fall detector for one video timing signal, sampled only on pixel
// enables so sub-pixel glitches never register.
module video_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic ce_pix,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       q <= 1'b0;
    else if (ce_pix) q <= sig;
  end

  assign rise = ce_pix & sig & ~q;
  assign fall = ce_pix & ~sig & q;

endmodule

// File: rtl/video_timing_meter.sv
// Raster geometry, mode and luma measurement with frame-stability lock
// tracking for the common video bus.
module video_timing_meter
  import video_meter_pkg::*;
#(
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned CW          = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce_pix,
  input  logic          HBlank,
  input  logic          HSync,
  input  logic          VBlank,
  input  logic          VSync,
  input  logic [7:0]    video,
  output logic [CW-1:0] h_total,
  output logic [CW-1:0] h_active,
  output logic [CW-1:0] hs_width,
  output logic [CW-1:0] v_total,
  output logic [CW-1:0] v_active,
  output logic [26:0]   luma_sum,
  output logic [1:0]    mode,
  output logic          mode_valid,
  output logic          locked,
  output logic          timeout,
  output logic          frame_stb
);

  localparam logic [3:0] LOCK_THR = 4'(LOCK_FRAMES - 1);

  logic hs_rise, hs_fall, vs_rise, vs_fall, hb_rise, hb_fall;
  logic unused_edges;

  video_edge_det u_hs (.clk(clk), .reset(reset), .ce_pix(ce_pix), .sig(HSync),  .rise(hs_rise), .fall(hs_fall));
  video_edge_det u_vs (.clk(clk), .reset(reset), .ce_pix(ce_pix), .sig(VSync),  .rise(vs_rise), .fall(vs_fall));
  video_edge_det u_hb (.clk(clk), .reset(reset), .ce_pix(ce_pix), .sig(HBlank), .rise(hb_rise), .fall(hb_fall));

  assign unused_edges = vs_fall ^ hb_rise ^ hb_fall;

  logic [CW-1:0] hcnt, hacnt, hswc, vline, vacnt;
  logic [CW-1:0] h_total_w, h_active_w, hs_width_w;
  logic [26:0]   luma_acc;
  logic          active_px, sat;

  // "_n" values fold in the current pixel, so a line ending on the vs_rise
  // pixel is already part of the frame being published.
  logic [CW-1:0] h_total_n, h_active_n, hs_width_n, v_total_n, v_active_n;
  logic [26:0]   luma_n;

  assign active_px  = ce_pix & ~HBlank & ~VBlank;
  assign h_total_n  = hs_rise ? ((&hcnt) ? hcnt : hcnt + 1'b1) : h_total_w;
  assign h_active_n = hs_rise ? hacnt : h_active_w;
  assign hs_width_n = hs_fall ? hswc : hs_width_w;
  assign v_total_n  = vline + {{(CW-1){1'b0}}, hs_rise};
  assign v_active_n = vacnt + {{(CW-1){1'b0}}, hs_rise & ~VBlank};
  assign luma_n     = luma_acc + (active_px ? {19'd0, video} : 27'd0);
  assign sat        = ce_pix & (((&hcnt) & ~hs_rise) | ((&vline) & hs_rise & ~vs_rise));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt       <= '0;
      hacnt      <= '0;
      hswc       <= '0;
      vline      <= '0;
      vacnt      <= '0;
      h_total_w  <= '0;
      h_active_w <= '0;
      hs_width_w <= '0;
      luma_acc   <= '0;
    end else if (ce_pix) begin
      if (hs_rise) begin
        hcnt       <= '0;
        h_total_w  <= h_total_n;
        h_active_w <= hacnt;
        hacnt      <= {{(CW-1){1'b0}}, ~HBlank};
        hswc       <= {{(CW-1){1'b0}}, 1'b1};
      end else begin
        if (~&hcnt) hcnt <= hcnt + 1'b1;
        if (~HBlank && ~&hacnt) hacnt <= hacnt + 1'b1;
        if (HSync && ~&hswc) hswc <= hswc + 1'b1;
      end
      if (hs_fall) hs_width_w <= hswc;
      if (vs_rise) begin
        vline    <= '0;
        vacnt    <= '0;
        luma_acc <= '0;
      end else begin
        if (hs_rise && ~&vline) vline <= vline + 1'b1;
        if (hs_rise && ~VBlank && ~&vacnt) vacnt <= vacnt + 1'b1;
        luma_acc <= luma_n;
      end
    end
  end

  state_t     state, state_n;
  logic [3:0] stable_cnt, stable_n, stable_inc;
  logic       upd, tuple_match;

  assign tuple_match = ({h_total_n, h_active_n, v_total_n} == {h_total, h_active, v_total});
  assign stable_inc  = (&stable_cnt) ? stable_cnt : stable_cnt + 4'd1;

  always_comb begin
    state_n  = state;
    stable_n = stable_cnt;
    upd      = 1'b0;
    unique case (state)
      IDLE: if (vs_rise) state_n = MEASURE;
      MEASURE: if (vs_rise) begin
        upd = 1'b1;
        if (tuple_match) begin
          stable_n = stable_inc;
          if (stable_inc >= LOCK_THR) state_n = LOCKED;
        end else begin
          stable_n = '0;
        end
      end
      LOCKED: if (vs_rise) begin
        upd = 1'b1;
        if (!tuple_match) begin
          state_n  = MEASURE;
          stable_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
    if (sat) begin
      state_n  = MEASURE;
      stable_n = '0;
    end
  end

  logic [31:0] vt_ext;
  logic [1:0]  mode_dec;
  logic        dec_valid;

  assign vt_ext = 32'(v_total_n);

  always_comb begin
    mode_dec  = mode;
    dec_valid = 1'b1;
    case (vt_ext)
      LINES_NTSC15: mode_dec = MODE_NTSC15;
      LINES_PAL15:  mode_dec = MODE_PAL15;
      LINES_NTSC31: mode_dec = MODE_NTSC31;
      LINES_PAL31:  mode_dec = MODE_PAL31;
      default:      dec_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      stable_cnt <= '0;
      h_total    <= '0;
      h_active   <= '0;
      hs_width   <= '0;
      v_total    <= '0;
      v_active   <= '0;
      luma_sum   <= '0;
      mode       <= '0;
      mode_valid <= 1'b0;
      timeout    <= 1'b0;
      frame_stb  <= 1'b0;
    end else begin
      state      <= state_n;
      stable_cnt <= stable_n;
      frame_stb  <= upd;
      if (sat) timeout <= 1'b1;
      if (upd) begin
        h_total    <= h_total_n;
        h_active   <= h_active_n;
        hs_width   <= hs_width_n;
        v_total    <= v_total_n;
        v_active   <= v_active_n;
        luma_sum   <= luma_n;
        mode       <= mode_dec;
        mode_valid <= dec_valid;
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule
